// File: rtl/bpu_upd_ctrl.sv
// Branch predictor update controller: turns commit-stage branch reports into
// redirect pulses (mispredicts) and queued reinforce pulses (weak, correct).
module bpu_upd_ctrl #(
    parameter int qdep  = 8,
    parameter int quiet = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmt_vld,
    output logic        cmt_rdy,
    input  logic        cmt_mis,
    input  logic [63:0] cmt_pc,
    input  logic [63:0] cmt_npc,
    input  logic [1:0]  cmt_pat,
    output logic        redir,
    output logic        reinf,
    output logic [63:0] upc,
    output logic [63:0] unpc,
    output logic [1:0]  upat,
    output logic [31:0] n_br,
    output logic [31:0] n_mis
);

    localparam int aw = $clog2(qdep);

    // Handshake: a report transfers on a clock edge where cmt_vld & cmt_rdy.
    // cmt_rdy depends only on the registered occupancy count.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        REDIR = 2'd1,
        QUIET = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    qcnt_q, qcnt_d;
    logic [aw-1:0] wr_ptr, rd_ptr;
    logic [aw:0]   count;
    logic [63:0]   q_pc  [qdep];
    logic [63:0]   q_npc [qdep];
    logic [1:0]    q_pat [qdep];

    logic full, empty, acc, acc_mis, acc_weak, run_next, pop;

    assign full     = (count == (aw+1)'(qdep));
    assign empty    = (count == '0);
    assign cmt_rdy  = !full;
    assign acc      = cmt_vld & cmt_rdy;
    assign acc_mis  = acc & cmt_mis;
    assign acc_weak = acc & !cmt_mis & (cmt_pat[1] ^ cmt_pat[0]);

    // run_next: the following cycle is a RUN cycle, so a pop now lands its
    // reinforce pulse just outside the quiet window.
    always_comb begin
        state_d  = state_q;
        qcnt_d   = qcnt_q;
        run_next = 1'b0;
        case (state_q)
            RUN: begin
                run_next = 1'b1;
            end
            REDIR: begin
                qcnt_d = 4'(quiet);
                if (quiet == 0) begin
                    state_d  = RUN;
                    run_next = 1'b1;
                end else begin
                    state_d = QUIET;
                end
            end
            QUIET: begin
                qcnt_d = qcnt_q - 4'd1;
                if (qcnt_q <= 4'd1) begin
                    state_d  = RUN;
                    run_next = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (acc_mis) begin
            state_d = REDIR;
        end
    end

    assign pop = run_next & !acc_mis & !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            qcnt_q  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            redir   <= 1'b0;
            reinf   <= 1'b0;
            upc     <= '0;
            unpc    <= '0;
            upat    <= '0;
            n_br    <= '0;
            n_mis   <= '0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            redir   <= acc_mis;
            reinf   <= pop;
            if (acc_mis) begin
                upc  <= cmt_pc;
                unpc <= cmt_npc;
                upat <= cmt_pat;
            end else if (pop) begin
                upc  <= q_pc[rd_ptr];
                unpc <= q_npc[rd_ptr];
                upat <= q_pat[rd_ptr];
            end
            if (acc_weak) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({acc_weak, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (acc) begin
                n_br <= n_br + 32'd1;
            end
            if (acc_mis) begin
                n_mis <= n_mis + 32'd1;
            end
        end
    end

    // Storage needs no reset; entries are only read behind the count.
    always_ff @(posedge clk) begin
        if (acc_weak) begin
            q_pc[wr_ptr]  <= cmt_pc;
            q_npc[wr_ptr] <= cmt_npc;
            q_pat[wr_ptr] <= cmt_pat;
        end
    end

endmodule

// File: tb/tb_bpu_upd_ctrl.sv
// Bench for bpu_upd_ctrl: directed scenarios then random reports, checked
// every cycle against a window/queue reference model and payload scoreboards.
module tb_bpu_upd_ctrl;

    localparam int QDEP  = 8;
    localparam int QUIET = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmt_vld = 1'b0;
    logic        cmt_rdy;
    logic        cmt_mis = 1'b0;
    logic [63:0] cmt_pc = '0;
    logic [63:0] cmt_npc = '0;
    logic [1:0]  cmt_pat = '0;
    logic        redir, reinf;
    logic [63:0] upc, unpc;
    logic [1:0]  upat;
    logic [31:0] n_br, n_mis;

    bpu_upd_ctrl #(.qdep(QDEP), .quiet(QUIET)) dut (
        .clk(clk), .rst(rst),
        .cmt_vld(cmt_vld), .cmt_rdy(cmt_rdy), .cmt_mis(cmt_mis),
        .cmt_pc(cmt_pc), .cmt_npc(cmt_npc), .cmt_pat(cmt_pat),
        .redir(redir), .reinf(reinf),
        .upc(upc), .unpc(unpc), .upat(upat),
        .n_br(n_br), .n_mis(n_mis)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    logic [129:0] exp_q[$];    // weak reports, oldest first
    logic [129:0] exp_r_q[$];  // mispredict payloads
    logic [129:0] exp_u = '0;
    int           occ = 0;     // entries held inside the block
    int           cyc = 0;
    int           last_redir = -1000;
    logic         exp_redir = 1'b0;
    logic         exp_reinf = 1'b0;
    logic [31:0]  exp_br = '0;
    logic [31:0]  exp_mis = '0;
    logic         chk_on = 1'b0;
    logic         acc_m, pop_m;

    // Monitor: outputs of this cycle are checked, then the model steps over
    // the coming clock edge using the inputs currently presented.
    always @(negedge clk) begin
        cyc++;
        if (chk_on) begin
            chk("redir", 64'(redir), 64'(exp_redir));
            chk("reinf", 64'(reinf), 64'(exp_reinf));
            chk("redir_and_reinf", 64'(redir & reinf), 64'd0);
            if (redir) begin
                if (exp_r_q.size() > 0) exp_u = exp_r_q.pop_front();
                else chk("redir_payload_avail", 64'd0, 64'd1);
            end else if (reinf) begin
                if (exp_q.size() > 0) exp_u = exp_q.pop_front();
                else chk("reinf_payload_avail", 64'd0, 64'd1);
            end
            chk("upc", upc, exp_u[129:66]);
            chk("unpc", unpc, exp_u[65:2]);
            chk("upat", 64'(upat), 64'(exp_u[1:0]));
            chk("n_br", 64'(n_br), 64'(exp_br));
            chk("n_mis", 64'(n_mis), 64'(exp_mis));
            chk("cmt_rdy", 64'(cmt_rdy), 64'(occ < QDEP));
        end
        if (rst) begin
            chk_on     = 1'b1;
            exp_q.delete();
            exp_r_q.delete();
            exp_u      = '0;
            occ        = 0;
            last_redir = -1000;
            exp_redir  = 1'b0;
            exp_reinf  = 1'b0;
            exp_br     = '0;
            exp_mis    = '0;
        end else if (chk_on) begin
            acc_m = cmt_vld && (occ < QDEP);
            // Reinforce may land next cycle only outside the quiet window
            // and never alongside a redirect.
            pop_m = (occ > 0) && !(acc_m && cmt_mis) && ((cyc + 1 - last_redir) > QUIET);
            exp_redir = acc_m && cmt_mis;
            exp_reinf = pop_m;
            if (exp_redir) last_redir = cyc + 1;
            if (pop_m) occ--;
            if (acc_m) begin
                exp_br++;
                if (cmt_mis) begin
                    exp_mis++;
                    exp_r_q.push_back({cmt_pc, cmt_npc, cmt_pat});
                end else if (cmt_pat == 2'b01 || cmt_pat == 2'b10) begin
                    exp_q.push_back({cmt_pc, cmt_npc, cmt_pat});
                    occ++;
                end
            end
        end
    end

    task automatic send(input logic mis, input logic [63:0] pc, input logic [63:0] npc,
                        input logic [1:0] pat);
        int   waited = 0;
        logic done = 1'b0;
        cmt_vld = 1'b1;
        cmt_mis = mis;
        cmt_pc  = pc;
        cmt_npc = npc;
        cmt_pat = pat;
        while (!done && waited < 200) begin
            @(negedge clk);
            if (cmt_rdy) done = 1'b1;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL send_timeout: got no accept in %0d cycles expected accept", waited);
        end
        cmt_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        cmt_vld = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst     = 1'b1;
        cmt_vld = 1'b1;
        cmt_mis = 1'b1;
        cmt_pc  = 64'hdead_beef_0000_0000;
        cmt_npc = 64'h1;
        cmt_pat = 2'b01;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst     = 1'b0;
        cmt_vld = 1'b0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        do_reset(3);
        idle(2);

        // single mispredict
        send(1'b1, 64'h8000_0010, 64'h8000_0100, 2'b01);
        idle(5);

        // weak, strong, weak back to back
        send(1'b0, 64'h1000, 64'h1004, 2'b10);
        send(1'b0, 64'h2000, 64'h2004, 2'b11);
        send(1'b0, 64'h3000, 64'h3004, 2'b01);
        idle(6);

        // fill while repeated mispredicts hold off draining, then a held 9th
        for (int g = 0; g < 4; g++) begin
            send(1'b1, 64'h9000 + 64'(g), 64'h9100, 2'b00);
            send(1'b0, 64'h4000 + 64'(2*g), 64'h5000, 2'b10);
            send(1'b0, 64'h4001 + 64'(2*g), 64'h5001, 2'b01);
        end
        send(1'b0, 64'h4100, 64'h5100, 2'b01);
        idle(15);

        // weak then mispredict next cycle
        send(1'b0, 64'h6000, 64'h6004, 2'b10);
        send(1'b1, 64'h7000, 64'h7800, 2'b11);
        idle(8);

        // two mispredicts back to back
        send(1'b1, 64'hA000, 64'hA100, 2'b00);
        send(1'b1, 64'hB000, 64'hB100, 2'b10);
        idle(8);

        // reset with entries queued during the quiet window
        send(1'b1, 64'hC000, 64'hC100, 2'b00);
        send(1'b0, 64'hC010, 64'hC014, 2'b01);
        send(1'b0, 64'hC020, 64'hC024, 2'b10);
        send(1'b1, 64'hC030, 64'hC100, 2'b00);
        send(1'b0, 64'hC040, 64'hC044, 2'b01);
        do_reset(1);
        idle(6);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset($urandom_range(1, 2));
            end else if (r < 20) begin
                idle($urandom_range(1, 3));
            end else begin
                send($urandom_range(0, 99) < (i < 750 ? 15 : 40), rnd64(), rnd64(),
                     2'($urandom_range(0, 3)));
            end
        end

        idle(40);
        chk("drain_weak_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_redir_empty", 64'(exp_r_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
